// File: rtl/rom_top_256x8.sv
// -----------------------------------------------------------------------------
// rom_top_256x8
//
// Purpose:
//   Synchronous 256 x 8 read-only lookup table holding one full period of an
//   unsigned sine wave:
//     rom[a] = floor(127.5 + 127.5*sin(2*pi*a/256) + 0.5)
//   A read happens on every rising clock edge; there is no enable. Every
//   address is valid.
//
// Ports:
//   iws_clk   in   1  system clock, rising edge
//   iws_rst   in   1  synchronous active-high reset; clears every pipeline
//                     register to 8'h00 and discards the address presented
//   iwv_addr  in   8  read address, sampled every rising edge
//   owv_q     out  8  registered read data (direct flop output)
//
// Configuration:
//   ROM_OUTREG_EN  defined   : extra output register, 2-cycle latency
//                  undefined : single register stage, 1-cycle latency
//   Table contents and reset behaviour are the same in both builds.
//
// Stream semantics: no valid/ready; the block accepts one address per cycle
// unconditionally and produces one sample per cycle after the fixed latency.
// -----------------------------------------------------------------------------
module rom_top_256x8 (
    input  logic       iws_clk,
    input  logic       iws_rst,
    input  logic [7:0] iwv_addr,
    output logic [7:0] owv_q
);

    // Only the first quarter (a = 0..64) is stored. The rest is folded:
    //   rom[128 - k] = rom[k]               (sin symmetric about a = 64)
    //   rom[128 + k] = 255 - rom[k], k != 0  (floor of a non-integer negated)
    //   rom[128]     = 128                   (sin is exactly zero there)
    logic [6:0] half_idx;
    logic [6:0] quarter_idx;
    logic [7:0] quarter_val;
    logic [7:0] rom_d;
    logic [7:0] data_q;

    assign half_idx    = iwv_addr[6:0];
    assign quarter_idx = (half_idx > 7'd64) ? (7'd0 - half_idx) : half_idx;

    always_comb begin
        quarter_val = 8'd255;
        case (quarter_idx)
            7'd0:  quarter_val = 8'd128;
            7'd1:  quarter_val = 8'd131;
            7'd2:  quarter_val = 8'd134;
            7'd3:  quarter_val = 8'd137;
            7'd4:  quarter_val = 8'd140;
            7'd5:  quarter_val = 8'd143;
            7'd6:  quarter_val = 8'd146;
            7'd7:  quarter_val = 8'd149;
            7'd8:  quarter_val = 8'd152;
            7'd9:  quarter_val = 8'd155;
            7'd10: quarter_val = 8'd158;
            7'd11: quarter_val = 8'd162;
            7'd12: quarter_val = 8'd165;
            7'd13: quarter_val = 8'd167;
            7'd14: quarter_val = 8'd170;
            7'd15: quarter_val = 8'd173;
            7'd16: quarter_val = 8'd176;
            7'd17: quarter_val = 8'd179;
            7'd18: quarter_val = 8'd182;
            7'd19: quarter_val = 8'd185;
            7'd20: quarter_val = 8'd188;
            7'd21: quarter_val = 8'd190;
            7'd22: quarter_val = 8'd193;
            7'd23: quarter_val = 8'd196;
            7'd24: quarter_val = 8'd198;
            7'd25: quarter_val = 8'd201;
            7'd26: quarter_val = 8'd203;
            7'd27: quarter_val = 8'd206;
            7'd28: quarter_val = 8'd208;
            7'd29: quarter_val = 8'd211;
            7'd30: quarter_val = 8'd213;
            7'd31: quarter_val = 8'd215;
            7'd32: quarter_val = 8'd218;
            7'd33: quarter_val = 8'd220;
            7'd34: quarter_val = 8'd222;
            7'd35: quarter_val = 8'd224;
            7'd36: quarter_val = 8'd226;
            7'd37: quarter_val = 8'd228;
            7'd38: quarter_val = 8'd230;
            7'd39: quarter_val = 8'd232;
            7'd40: quarter_val = 8'd234;
            7'd41: quarter_val = 8'd235;
            7'd42: quarter_val = 8'd237;
            7'd43: quarter_val = 8'd238;
            7'd44: quarter_val = 8'd240;
            7'd45: quarter_val = 8'd241;
            7'd46: quarter_val = 8'd243;
            7'd47: quarter_val = 8'd244;
            7'd48: quarter_val = 8'd245;
            7'd49: quarter_val = 8'd246;
            7'd50: quarter_val = 8'd248;
            7'd51: quarter_val = 8'd249;
            7'd52: quarter_val = 8'd250;
            7'd53: quarter_val = 8'd250;
            7'd54: quarter_val = 8'd251;
            7'd55: quarter_val = 8'd252;
            7'd56: quarter_val = 8'd253;
            7'd57: quarter_val = 8'd253;
            7'd58: quarter_val = 8'd254;
            7'd59: quarter_val = 8'd254;
            7'd60: quarter_val = 8'd254;
            7'd61: quarter_val = 8'd255;
            7'd62: quarter_val = 8'd255;
            7'd63: quarter_val = 8'd255;
            7'd64: quarter_val = 8'd255;
            // 65..127 cannot occur after folding.
            default: quarter_val = 8'd255;
        endcase
    end

    always_comb begin
        rom_d = quarter_val;
        if (iwv_addr[7]) begin
            // 255 - x is a plain bitwise inversion for 8-bit x.
            rom_d = (half_idx == 7'd0) ? 8'd128 : ~quarter_val;
        end
    end

    // Table register: the only stage in the default build.
    always_ff @(posedge iws_clk) begin
        if (iws_rst) begin
            data_q <= 8'h00;
        end else begin
            data_q <= rom_d;
        end
    end

`ifdef ROM_OUTREG_EN
    logic [7:0] out_q;

    // Extra output stage for timing closure; cleared together with data_q so
    // no in-flight sample survives a reset.
    always_ff @(posedge iws_clk) begin
        if (iws_rst) begin
            out_q <= 8'h00;
        end else begin
            out_q <= data_q;
        end
    end

    assign owv_q = out_q;
`else
    assign owv_q = data_q;
`endif

endmodule

// File: tb/tb_rom_top_256x8.sv
module tb_rom_top_256x8;

`ifdef ROM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       iws_clk;
  logic       iws_rst;
  logic [7:0] iwv_addr;
  logic [7:0] owv_q;

  initial iws_clk = 1'b0;
  always #10 iws_clk = ~iws_clk;

  rom_top_256x8 dut (
    .iws_clk  (iws_clk),
    .iws_rst  (iws_rst),
    .iwv_addr (iwv_addr),
    .owv_q    (owv_q)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [7:0] exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference sine formula in real arithmetic.
  function automatic logic [7:0] sine_model(input int a);
    real s;
    int  v;
    s = $sin(2.0 * 3.14159265358979323846 * real'(a) / 256.0);
    v = $rtoi($floor(127.5 + 127.5 * s + 0.5));
    return v[7:0];
  endfunction

  // Documented anchor values are used verbatim; everything else from the formula.
  function automatic logic [7:0] expected_for(input logic [7:0] a);
    case (a)
      8'd0:    return 8'd128;
      8'd1:    return 8'd131;
      8'd32:   return 8'd218;
      8'd64:   return 8'd255;
      8'd128:  return 8'd128;
      8'd192:  return 8'd0;
      8'd255:  return 8'd124;
      default: return sine_model(int'(a));
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one clock per call. Inputs change 1 time unit after the rising
  // edge; the output is sampled at the same point, away from the edge.
  // ---------------------------------------------------------------------------
  task automatic cycle(input logic rst, input logic [7:0] addr, input string tag);
    logic [7:0] exp;
    iws_rst  = rst;
    iwv_addr = addr;
    if (rst) begin
      // Reset flushes every read still in flight.
      foreach (exp_q[i]) exp_q[i] = 8'h00;
      exp_q.push_back(8'h00);
    end else begin
      exp_q.push_back(expected_for(addr));
    end
    @(posedge iws_clk);
    #1;
    if (rst) check({tag, "_rst_out"}, owv_q, 8'h00);
    if (exp_q.size() >= LAT) begin
      exp = exp_q.pop_front();
      check(tag, owv_q, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    iws_rst  = 1'b1;
    iwv_addr = 8'd64;
    @(posedge iws_clk);
    #1;

    // Reset held with address 64 presented, then release on the same address.
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'd64, "reset");
    for (int i = 0; i < LAT; i++) cycle(1'b0, 8'd64, "first_data");

    // Ramp with wrap: about 3.9 periods, every sample checked.
    for (int i = 0; i < 1000; i++) cycle(1'b0, 8'(i % 256), "ramp");

    // Explicit wrap sequence.
    cycle(1'b0, 8'd254, "wrap");
    cycle(1'b0, 8'd255, "wrap");
    cycle(1'b0, 8'd0,   "wrap");
    cycle(1'b0, 8'd1,   "wrap");

    // Random reads.
    for (int i = 0; i < 500; i++) cycle(1'b0, 8'($urandom_range(0, 255)), "rand");

    // Single-cycle reset in the middle of a ramp, at address 100.
    for (int i = 90; i < 120; i++) begin
      if (i == 100) cycle(1'b1, 8'(i), "midrst");
      else          cycle(1'b0, 8'(i), "midrst");
    end

    // Drain the pipeline.
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'd192, "drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
